// File: rtl/rx_sample_timer.sv
// rx_sample_timer
// ---------------
// Bit-timing engine for the UART receiver. While enable is high it counts
// oversampling edges (1..P) within each bit and bit periods (1..L) across a
// frame. It takes a 3-sample majority vote around the middle of every bit.
// It also flags a start bit that votes high (a glitch) and the end of the frame.
//
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   enable       in   level from the RX FSM; low aborts at the next edge
//   prescale     in   oversampling edges per bit (legal >= 4), latched at start
//   frame_len    in   bit periods per frame (legal >= 2), latched at start
//   rx_in        in   synchronised serial input
//   edge_cnt     out  current edge within the bit, 0 when not running
//   bit_cnt      out  current bit within the frame, 0 when not running
//   sampled_bit  out  majority-voted value of the last sampled bit
//   sample_valid out  one-cycle pulse, sampled_bit was just updated
//   start_glitch out  one-cycle pulse, start bit voted 1 (frame abandoned)
//   frame_done   out  one-cycle pulse, last edge of last bit was reached
//   cfg_err      out  level, latched configuration was illegal
//   dbg_state_o  out  FSM state for observation (0 IDLE, 1 RUN, 2 HOLD)
//
// Protocol: there is no valid/ready handshake. enable is a level. The three
// pulse outputs are registered and last exactly one cycle. The pulses have no
// back-pressure, so the consumer must take them in the cycle they are high.
// When enable falls, it overrides any pulse due on that same edge.

module rx_sample_timer #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  frame_len,
    input  logic                  rx_in,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  sampled_bit,
    output logic                  sample_valid,
    output logic                  start_glitch,
    output logic                  frame_done,
    output logic                  cfg_err,
    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PRESCALE_W-1:0] p_q, p_d;
    logic [BIT_CNT_W-1:0]  l_q, l_d;
    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_CNT_W-1:0]  bit_q, bit_d;
    logic                  s0_q, s0_d;
    logic                  s1_q, s1_d;
    logic                  sampled_q, sampled_d;
    logic                  sv_q, sv_d;
    logic                  sg_q, sg_d;
    logic                  fd_q, fd_d;
    logic                  cfg_q, cfg_d;

    logic [PRESCALE_W-1:0] mid;
    logic                  vote;
    logic                  cfg_ok;
    logic                  at_vote;

    // Mid-point of the bit, taken from the latched prescale.
    assign mid     = p_q >> 1;
    // s0 was taken at mid-1 and s1 at mid. The third sample is the live rx_in at mid+1.
    assign vote    = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
    assign at_vote = (edge_q == mid + PRESCALE_W'(1));
    assign cfg_ok  = (prescale >= PRESCALE_W'(4)) && (frame_len >= BIT_CNT_W'(2));

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        l_d       = l_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        sampled_d = sampled_q;
        sv_d      = 1'b0;
        sg_d      = 1'b0;
        fd_d      = 1'b0;
        cfg_d     = cfg_q;

        if (!enable) begin
            // Abort takes priority over everything, including due pulses.
            state_d = ST_IDLE;
            edge_d  = '0;
            bit_d   = '0;
            cfg_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    edge_d = '0;
                    bit_d  = '0;
                    if (cfg_ok) begin
                        p_d     = prescale;
                        l_d     = frame_len;
                        edge_d  = PRESCALE_W'(1);
                        bit_d   = BIT_CNT_W'(1);
                        state_d = ST_RUN;
                    end else begin
                        cfg_d   = 1'b1;
                        state_d = ST_HOLD;
                    end
                end

                ST_RUN: begin
                    if (edge_q == mid - PRESCALE_W'(1)) s0_d = rx_in;
                    if (edge_q == mid)                  s1_d = rx_in;
                    if (at_vote) begin
                        sampled_d = vote;
                        sv_d      = 1'b1;
                    end

                    // A start bit that votes high is a glitch and ends the frame.
                    // Because P >= 4, mid+1 is always below P, so this case
                    // never coincides with the end-of-bit branch.
                    if (at_vote && (bit_q == BIT_CNT_W'(1)) && vote) begin
                        sg_d    = 1'b1;
                        edge_d  = '0;
                        bit_d   = '0;
                        state_d = ST_HOLD;
                    end else if (edge_q != p_q) begin
                        edge_d = edge_q + PRESCALE_W'(1);
                    end else if (bit_q != l_q) begin
                        edge_d = PRESCALE_W'(1);
                        bit_d  = bit_q + BIT_CNT_W'(1);
                    end else begin
                        fd_d    = 1'b1;
                        edge_d  = '0;
                        bit_d   = '0;
                        state_d = ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    edge_d = '0;
                    bit_d  = '0;
                end

                default: begin
                    state_d = ST_IDLE;
                    edge_d  = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            p_q       <= '0;
            l_q       <= '0;
            edge_q    <= '0;
            bit_q     <= '0;
            s0_q      <= 1'b1;
            s1_q      <= 1'b1;
            sampled_q <= 1'b1;
            sv_q      <= 1'b0;
            sg_q      <= 1'b0;
            fd_q      <= 1'b0;
            cfg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            l_q       <= l_d;
            edge_q    <= edge_d;
            bit_q     <= bit_d;
            s0_q      <= s0_d;
            s1_q      <= s1_d;
            sampled_q <= sampled_d;
            sv_q      <= sv_d;
            sg_q      <= sg_d;
            fd_q      <= fd_d;
            cfg_q     <= cfg_d;
        end
    end

    assign edge_cnt     = edge_q;
    assign bit_cnt      = bit_q;
    assign sampled_bit  = sampled_q;
    assign sample_valid = sv_q;
    assign start_glitch = sg_q;
    assign frame_done   = fd_q;
    assign cfg_err      = cfg_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_rx_sample_timer.sv
module tb_rx_sample_timer;
  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [BW-1:0] frame_len;
  logic          rx_in;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sampled_bit;
  logic          sample_valid;
  logic          start_glitch;
  logic          frame_done;
  logic          cfg_err;
  logic [1:0]    dbg_state;

  int   checks = 0;
  int   errors = 0;
  int   rx_seq [0:1023];
  logic exp_sampled = 1'b1;

  rx_sample_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .prescale     (prescale),
    .frame_len    (frame_len),
    .rx_in        (rx_in),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .start_glitch (start_glitch),
    .frame_done   (frame_done),
    .cfg_err      (cfg_err),
    .dbg_state_o  (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string name, input int k, input int e, input int b,
                           input bit sv, input bit sg, input bit fd, input bit cfg);
    check($sformatf("%s[%0d] edge_cnt", name, k), 32'(edge_cnt), 32'(e));
    check($sformatf("%s[%0d] bit_cnt", name, k), 32'(bit_cnt), 32'(b));
    check($sformatf("%s[%0d] sample_valid", name, k), 32'(sample_valid), 32'(sv));
    check($sformatf("%s[%0d] start_glitch", name, k), 32'(start_glitch), 32'(sg));
    check($sformatf("%s[%0d] frame_done", name, k), 32'(frame_done), 32'(fd));
    check($sformatf("%s[%0d] cfg_err", name, k), 32'(cfg_err), 32'(cfg));
    check($sformatf("%s[%0d] sampled_bit", name, k), 32'(sampled_bit), 32'(exp_sampled));
  endtask

  function automatic int maj(input int a, input int b, input int c);
    return ((a + b + c) >= 2) ? 1 : 0;
  endfunction

  // Line waveform: bit i of 'bits' is held for p cycles; idle high afterwards.
  task automatic fill_bits(input int p, input int l, input logic [15:0] bits);
    for (int k = 0; k < 1024; k++) begin
      if (k < p * l) rx_seq[k] = int'(bits[k / p]);
      else           rx_seq[k] = 1;
    end
  endtask

  // Runs one frame and compares every cycle against a timing model.
  // Run cycle k covers bit k/P+1 at edge k%P+1. The vote for a bit covers the
  // cycles at edges M-1..M+1. It becomes visible at edge M+2.
  task automatic run_frame(input string name, input int p, input int l, input int abort_k);
    int  m;
    int  total;
    int  last_k;
    bit  dead;
    m      = p / 2;
    total  = p * l;
    last_k = (abort_k >= 0) ? abort_k + 3 : total + 3;
    dead   = 1'b0;
    prescale  = PW'(p);
    frame_len = BW'(l);
    enable    = 1'b1;
    for (int k = 0; k <= last_k; k++) begin
      int e;
      int b;
      bit sv;
      bit sg;
      bit fd;
      int v;
      @(posedge clk); #1;
      e = 0; b = 0; sv = 0; sg = 0; fd = 0;
      if ((abort_k >= 0) && (k > abort_k)) begin
        e = 0;
      end else if (dead) begin
        e = 0;
      end else if (k < total) begin
        e = (k % p) + 1;
        b = (k / p) + 1;
        if (e == m + 2) begin
          v  = maj(rx_seq[k-3], rx_seq[k-2], rx_seq[k-1]);
          sv = 1'b1;
          exp_sampled = v[0];
          if ((b == 1) && (v == 1)) begin
            sg = 1'b1; e = 0; b = 0; dead = 1'b1;
          end
        end
      end else if (k == total) begin
        fd = 1'b1;
      end
      check_all(name, k, e, b, sv, sg, fd, 1'b0);
      rx_in = rx_seq[k][0];
      if (k == abort_k) enable = 1'b0;
      // Configuration changes while running must be ignored.
      if (k == 2) prescale  = PW'($urandom_range(0, 63));
      if (k == 4) frame_len = BW'($urandom_range(0, 15));
    end
    enable = 1'b0;
    @(posedge clk); #1;
    check_all({name, "_idle"}, -1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_cfg_err(input string name, input int p, input int l);
    prescale  = PW'(p);
    frame_len = BW'(l);
    enable    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_all(name, k, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    enable = 1'b0;
    @(posedge clk); #1;
    check_all({name, "_clr"}, 4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] bits;
    int          p;
    int          l;
    int          ak;

    // reset
    rst = 1'b0; enable = 1'b0; prescale = PW'(8); frame_len = BW'(10); rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // clean 0x55 frame: start 0, data LSB first, stop 1
    fill_bits(8, 10, 16'b0000_0010_1010_1010);
    run_frame("clean55", 8, 10, -1);

    // P=16 with a one-cycle glitch at edge 8 of every bit
    bits = 16'($urandom_range(0, 65535));
    bits[0] = 1'b0; bits[9] = 1'b1;
    fill_bits(16, 10, bits);
    for (int b = 0; b < 10; b++) rx_seq[b*16 + 7] = 1 - rx_seq[b*16 + 7];
    run_frame("glitch16", 16, 10, -1);

    // start bit low for 3 cycles, then high
    for (int k = 0; k < 1024; k++) rx_seq[k] = (k < 3) ? 0 : 1;
    run_frame("startglitch", 8, 10, -1);

    // illegal configuration
    run_cfg_err("cfg_p3", 3, 10);
    run_cfg_err("cfg_l1", 8, 1);

    // abort at bit 4 edge 2, then a new run with P=32
    fill_bits(8, 10, 16'b0000_0011_0110_0110);
    run_frame("abort", 8, 10, 3*8 + 1);
    fill_bits(32, 3, 16'b0000_0000_0000_0110);
    run_frame("p32", 32, 3, -1);

    // boundary configurations
    fill_bits(4, 2, 16'b0000_0000_0000_0010);
    run_frame("p4l2", 4, 2, -1);
    fill_bits(5, 15, 16'b0101_1001_1100_1010);
    run_frame("p5l15", 5, 15, -1);
    fill_bits(63, 2, 16'b0000_0000_0000_0010);
    run_frame("p63l2", 63, 2, -1);

    // randomized frames with line noise and occasional aborts
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(4, 12);
      l = $urandom_range(2, 10);
      bits = 16'($urandom_range(0, 65535));
      bits[0] = ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
      fill_bits(p, l, bits);
      for (int k = 0; k < p * l; k++)
        if ($urandom_range(0, 9) == 0) rx_seq[k] = 1 - rx_seq[k];
      ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, p * l - 1)) : -1;
      run_frame($sformatf("rand%0d", i), p, l, ak);
    end

    // asynchronous reset mid-frame, enable held high
    prescale = PW'(8); frame_len = BW'(10); rx_in = 1'b0; enable = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_sampled = 1'b1;
    check_all("rst_async", 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all("rst_restart", 1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    @(posedge clk); #1;
    check_all("rst_idle", 2, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_sample_timer.md
# rx_sample_timer

Parametrised bit-timing engine for the UART receiver. Counts oversampling edges and bit periods across a whole frame of programmable length, takes a 3-sample majority vote at the middle of each bit, and flags start-bit glitches and frame completion. It sits between the RX FSM, which drives `enable`, and the deserializer and parity/stop checkers, which consume `sampled_bit`/`sample_valid`.

## Interface
- PRESCALE_W, 6: width of prescale and edge counter.
- BIT_CNT_W, 4: width of frame length and bit counter.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  high while the RX FSM wants a frame timed; low aborts immediately.
- prescale  in  PRESCALE_W  oversampling edges per bit; legal ≥ 4.
- frame_len  in  BIT_CNT_W  bit periods per frame including start and stop bits; legal ≥ 2.
- rx_in  in  1  synchronised serial input.
- edge_cnt  out  PRESCALE_W  current edge within the bit, 1..prescale; 0 when not running.
- bit_cnt  out  BIT_CNT_W  current bit, 1..frame_len; 0 when not running.
- sampled_bit  out  1  majority-voted value of the last sampled bit.
- sample_valid  out  1  one-cycle pulse; `sampled_bit` is new.
- start_glitch  out  1  one-cycle pulse; start bit voted 1.
- frame_done  out  1  one-cycle pulse; last edge of the last bit reached.
- cfg_err  out  1  level; latched config illegal. Cleared when enable is low.

## Operation
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - edge_cnt = 0, bit_cnt = 0.
  - If enable = 1 and prescale ≥ 4 and frame_len ≥ 2: latch prescale→P and frame_len→L, set edge_cnt = 1 and bit_cnt = 1, go to RUN.
  - If enable = 1 and the config is illegal: set cfg_err = 1, go to HOLD.
- RUN:
  - If edge_cnt ≠ P: edge_cnt += 1.
  - Otherwise edge_cnt = 1 and:
    - if bit_cnt ≠ L: bit_cnt += 1;
    - if bit_cnt = L: frame_done = 1, both counters = 0, go to HOLD.
- HOLD: counters stay at 0. Leave for IDLE only when enable = 0.
- enable = 0 in any state: next cycle is IDLE, counters = 0, cfg_err = 0, no pulses. A partial bit produces no sample_valid.
- Mid-point: M = P >> 1 (floor). rx_in is captured when edge_cnt equals M−1, M and M+1.
- On the cycle edge_cnt = M+1:
  - register sampled_bit = majority(s0, s1, rx_in);
  - pulse sample_valid.
- If bit_cnt = 1 and the vote is 1:
  - pulse start_glitch together with sample_valid;
  - counters = 0, go to HOLD.
- Changes to prescale/frame_len while in RUN are ignored. Only the latched P and L are used.
- Counters never exceed P or L. There is no wrap past all-ones, because P ≤ 2^PRESCALE_W−1.

## Timing
- Reset values: edge_cnt = 0, bit_cnt = 0, sampled_bit = 1 (line idle), sample_valid = 0, start_glitch = 0, frame_done = 0, cfg_err = 0. State is IDLE.
- Start latency: enable seen high at edge t gives edge_cnt = 1 and bit_cnt = 1 after edge t.
- Frame length: the RUN state lasts exactly L·P cycles. frame_done is high for the single cycle after the last (edge_cnt = P, bit_cnt = L) cycle.
- sample_valid is high in the cycle where edge_cnt = M+2. sampled_bit holds until the next sample or reset.
- Pulse rules:
  - All pulses are registered.
  - frame_done and start_glitch are mutually exclusive.
  - sample_valid for bit L precedes frame_done by P−M−1 cycles.
- Simultaneous events: if enable falls on the same cycle a pulse would fire, the abort wins and no pulse is emitted.
- Reset asserted mid-frame: all outputs take their reset values asynchronously.

## Test plan
- P = 8, L = 10, clean frame 0x55 (start 0, LSB-first data, stop 1) → 80 RUN cycles; 10 sample_valid pulses at edge_cnt = 6 with sampled_bit = 0,1,0,1,0,1,0,1,0,1; frame_done one cycle after (edge 8, bit 10).
- P = 16, single-cycle glitch on rx_in at edge 8 of each bit → the majority vote ignores the glitch and every voted bit matches the transmitted value.
- rx_in low for 3 cycles then high during the start bit (P = 8) → start_glitch and sample_valid together at edge_cnt = 6 of bit 1, sampled_bit = 1; HOLD until enable drops; no frame_done.
- prescale = 3, or frame_len = 1, with enable = 1 → cfg_err = 1, counters stay at 0, no pulses; enable = 0 clears cfg_err.
- enable dropped at bit 4 edge 2, then raised again with P = 32 → counters 0 the next cycle; the new run uses P = 32. Changing prescale mid-run has no effect.
- rst pulsed low mid-frame → all outputs at reset values immediately; with enable held high, a new frame starts at the first edge after release.
